first_nios2_system_cpu_mul_seq: RTL and testbench
=================================================

Name: first_nios2_system_cpu_mul_seq

Overview:
Multiply sequencer that sits directly upstream and downstream of the CPU multiply cell. The cell computes the low 32 bits of a 32x32 product with registered latency.
- MUL: the sequencer passes full operands through the cell once.
- MULXUU / MULXSU / MULXSS: the sequencer issues four 16x16 partial products through the cell (zero-extended halves), accumulates a 64-bit product, applies signed correction, and returns the high word.
- Requests arrive and responses leave on valid/ready handshakes.

Parameters:
CELL_LATENCY, 1, cycles from driving mul_src1/mul_src2 to the matching mul_cell_result (range 1..3).

Ports:
clk  in  1  system clock; all logic rising-edge.
reset_n  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  sequencer can accept a request.
req_op  in  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS.
req_src1  in  32  operand A.
req_src2  in  32  operand B.
mul_src1  out  32  operand A to multiply cell.
mul_src2  out  32  operand B to multiply cell.
mul_cell_result  in  32  low 32 bits of the cell product, CELL_LATENCY cycles after issue.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer takes result.
rsp_result  out  32  low word (MUL) or high word (MULX*).

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE; capture pipeline, accumulator and pass counter clear.
  - rsp_valid=0, rsp_result=0, mul_src1=mul_src2=0.
  - req_ready=0 while reset_n is low.
- Reset mid-operation aborts the operation. No response is produced, and in-flight cell results are ignored.
- States: IDLE -> ISSUE -> DRAIN -> (FIX, MULX* only) -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready (accept edge = cycle 0): latch op/src1/src2, clear the 64-bit accumulator, pass=0, go to ISSUE.
  - req_ready=0 in every other state; there is no overlap of operations.
- ISSUE, one pass per cycle:
  - MUL: a single pass drives src1/src2 unchanged.
  - MULX*: passes 0..3 drive, in order, {A_lo,B_lo} shift 0, {A_hi,B_lo} shift 16, {A_lo,B_hi} shift 16, {A_hi,B_hi} shift 32. Each half is zero-extended to 32 bits.
  - After the last pass, go to DRAIN.
  - mul_src1/mul_src2 = 0 in all states except ISSUE.
- Capture:
  - A CELL_LATENCY-deep shift register carries {valid, shift} per issued pass.
  - When it emerges valid: MUL stores mul_cell_result; MULX* does acc += zero_ext64(mul_cell_result) << shift, using 64-bit arithmetic with carries kept.
  - Capture continues across the ISSUE->DRAIN boundary. DRAIN ends on the cycle the last pass is captured.
- FIX (1 cycle, MULX* only):
  - hi = acc[63:32].
  - MULXSU: hi -= (A[31] ? B : 0).
  - MULXSS: hi -= (A[31] ? B : 0) + (B[31] ? A : 0).
  - All subtraction is mod 2^32. MULXUU: no change.
- RESP:
  - rsp_valid=1; rsp_result is held stable until rsp_ready.
  - On rsp_valid&rsp_ready: go to IDLE; rsp_valid=0 next cycle; rsp_result keeps its last value.
  - rsp_ready held low: the block stalls indefinitely in RESP.
- Latency (rsp_ready=1), measured from the accept edge: rsp_valid first high in cycle 2+CELL_LATENCY for MUL and 6+CELL_LATENCY for MULX*. With CELL_LATENCY=1 that is 3 and 7.
- Back-to-back: the earliest next accept is the cycle after the response handshake.
- req_* inputs are ignored outside IDLE. Changing them after accept does not affect the operation.

Test Plan:
- MUL, src1=0x00010003, src2=0x00020005, rsp_ready=1 -> rsp_result=0x000B000F; rsp_valid high exactly in cycle 3; mul_src1/2 nonzero only in cycle 1.
- MULXUU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE in cycle 7. Check the four issued operand pairs: (0xFFFF,0xFFFF) in each of cycles 1..4.
- MULXSS, 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. Also 0x80000000 x 0x80000000 -> 0x40000000.
- MULXSU, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULXSU 0x00000002 x 0x80000000 -> 0x00000001.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=0. Issue a new request in the same cycle rsp_ready rises -> it is not accepted until the following cycle.
- Reset in cycle 3 of a MULXUU -> no rsp_valid; req_ready=1 the cycle after reset_n rises. A following MUL 7x6 -> 0x0000002A with no contamination. Repeat with CELL_LATENCY=3: latencies 5 and 9.

Source files
------------

// File: rtl/first_nios2_system_cpu_mul_seq.sv
// Multiply sequencer around the CPU multiply cell.
// MUL sends the full operands through the cell once and returns the low word.
// MULXUU/MULXSU/MULXSS send four zero-extended 16x16 partial products through
// the cell. The results are summed into a 64-bit accumulator, a signed
// correction is applied to the high word, and the high word is returned.
module first_nios2_system_cpu_mul_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_cell_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_FIX   = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;

    // Operand pair {src1, src2} that a given pass presents to the cell.
    function automatic logic [63:0] pass_operands(
        input logic [1:0]  op,
        input logic [1:0]  pass,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [63:0] ops;
        if (op == OP_MUL) begin
            ops = {a, b};
        end else begin
            case (pass)
                2'd0:    ops = {16'h0000, a[15:0],  16'h0000, b[15:0]};
                2'd1:    ops = {16'h0000, a[31:16], 16'h0000, b[15:0]};
                2'd2:    ops = {16'h0000, a[15:0],  16'h0000, b[31:16]};
                2'd3:    ops = {16'h0000, a[31:16], 16'h0000, b[31:16]};
                default: ops = 64'h0;
            endcase
        end
        return ops;
    endfunction

    // Left-shift to apply when the partial product of a pass comes back.
    function automatic logic [5:0] pass_shift(
        input logic [1:0] op,
        input logic [1:0] pass
    );
        logic [5:0] sh;
        if (op == OP_MUL) begin
            sh = 6'd0;
        end else begin
            case (pass)
                2'd0:    sh = 6'd0;
                2'd1:    sh = 6'd16;
                2'd2:    sh = 6'd16;
                2'd3:    sh = 6'd32;
                default: sh = 6'd0;
            endcase
        end
        return sh;
    endfunction

    // Turn the unsigned high word into the signed or mixed-sign high word.
    function automatic logic [31:0] fix_high(
        input logic [1:0]  op,
        input logic [31:0] hi,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] corr_a;
        logic [31:0] corr_b;
        case (op)
            OP_MULXSU: begin
                corr_a = a[31] ? b : 32'h0;
                corr_b = 32'h0;
            end
            OP_MULXSS: begin
                corr_a = a[31] ? b : 32'h0;
                corr_b = b[31] ? a : 32'h0;
            end
            OP_MULXUU: begin
                corr_a = 32'h0;
                corr_b = 32'h0;
            end
            default: begin
                corr_a = 32'h0;
                corr_b = 32'h0;
            end
        endcase
        return hi - corr_a - corr_b;
    endfunction

    logic [2:0]  state_r;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [1:0]  pass_r;
    logic [1:0]  cap_cnt_r;
    logic [63:0] acc_r;
    logic        ready_r;
    logic [31:0] mul_src1_r;
    logic [31:0] mul_src2_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_result_r;
    logic        pv_r [CELL_LATENCY];
    logic [5:0]  ps_r [CELL_LATENCY];

    logic [2:0]  next_state_s;
    logic [1:0]  next_pass_s;
    logic        accept_s;
    logic        cap_valid_s;
    logic [5:0]  cap_shift_s;
    logic [1:0]  last_pass_s;
    logic [31:0] fix_hi_s;
    logic [1:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [63:0] issue_ops_s;

    assign req_ready  = ready_r & reset_n;
    assign mul_src1   = mul_src1_r;
    assign mul_src2   = mul_src2_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;

    // Decode the handshake, the capture tap and the correction result.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && req_valid && ready_r;
        cap_valid_s = pv_r[CELL_LATENCY-1];
        cap_shift_s = ps_r[CELL_LATENCY-1];
        last_pass_s = (op_r == OP_MUL) ? 2'd0 : 2'd3;
        fix_hi_s    = fix_high(op_r, acc_r[63:32], a_r, b_r);
    end

    // Next state and next pass index.
    always_comb begin
        next_state_s = state_r;
        next_pass_s  = pass_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_ISSUE;
                    next_pass_s  = 2'd0;
                end else begin
                    next_state_s = ST_IDLE;
                    next_pass_s  = pass_r;
                end
            end
            ST_ISSUE: begin
                if (pass_r == last_pass_s) begin
                    next_state_s = ST_DRAIN;
                    next_pass_s  = pass_r;
                end else begin
                    next_state_s = ST_ISSUE;
                    next_pass_s  = pass_r + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (cap_valid_s && (cap_cnt_r == last_pass_s)) begin
                    next_state_s = (op_r == OP_MUL) ? ST_RESP : ST_FIX;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_FIX: begin
                next_state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_pass_s  = 2'd0;
            end
        endcase
    end

    // Operands for the next cycle's pass; the request is not latched yet at accept.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_op_s = req_op;
            sel_a_s  = req_src1;
            sel_b_s  = req_src2;
        end else begin
            sel_op_s = op_r;
            sel_a_s  = a_r;
            sel_b_s  = b_r;
        end
        issue_ops_s = pass_operands(sel_op_s, next_pass_s, sel_a_s, sel_b_s);
    end

    // Control state, pass counter, latched request and ready flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            pass_r  <= 2'd0;
            op_r    <= 2'd0;
            a_r     <= 32'h0;
            b_r     <= 32'h0;
            ready_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            pass_r  <= next_pass_s;
            ready_r <= (next_state_s == ST_IDLE);
            if (accept_s) begin
                op_r <= req_op;
                a_r  <= req_src1;
                b_r  <= req_src2;
            end else begin
                op_r <= op_r;
                a_r  <= a_r;
                b_r  <= b_r;
            end
        end
    end

    // Drive the cell only while issuing; it sees zeros otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mul_src1_r <= 32'h0;
            mul_src2_r <= 32'h0;
        end else if (next_state_s == ST_ISSUE) begin
            mul_src1_r <= issue_ops_s[63:32];
            mul_src2_r <= issue_ops_s[31:0];
        end else begin
            mul_src1_r <= 32'h0;
            mul_src2_r <= 32'h0;
        end
    end

    // Track each issued pass until its cell result comes back.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CELL_LATENCY; i++) begin
                pv_r[i] <= 1'b0;
                ps_r[i] <= 6'd0;
            end
        end else begin
            pv_r[0] <= (state_r == ST_ISSUE);
            ps_r[0] <= pass_shift(op_r, pass_r);
            for (int i = 1; i < CELL_LATENCY; i++) begin
                pv_r[i] <= pv_r[i-1];
                ps_r[i] <= ps_r[i-1];
            end
        end
    end

    // Accumulate the partial products that come back and count them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_r     <= 64'h0;
            cap_cnt_r <= 2'd0;
        end else if (accept_s) begin
            acc_r     <= 64'h0;
            cap_cnt_r <= 2'd0;
        end else if (cap_valid_s) begin
            if (op_r == OP_MUL) begin
                acc_r <= {32'h0, mul_cell_result};
            end else begin
                acc_r <= acc_r + ({32'h0, mul_cell_result} << cap_shift_s);
            end
            cap_cnt_r <= cap_cnt_r + 2'd1;
        end else begin
            acc_r     <= acc_r;
            cap_cnt_r <= cap_cnt_r;
        end
    end

    // Response register: load on entry to RESP, drop valid on handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 32'h0;
        end else if ((state_r == ST_DRAIN) && (next_state_s == ST_RESP)) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= mul_cell_result;
        end else if (state_r == ST_FIX) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= fix_hi_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= rsp_result_r;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
            rsp_result_r <= rsp_result_r;
        end
    end

endmodule

// File: tb/tb_first_nios2_system_cpu_mul_seq.sv
// Bench for the multiply sequencer. Instance 0 has a 1-cycle cell and
// instance 1 has a 3-cycle cell. Each instance has its own cell model.
module tb_first_nios2_system_cpu_mul_seq;

    logic        clk;
    logic        rst_n      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [1:0]  req_op     [2];
    logic [31:0] req_src1   [2];
    logic [31:0] req_src2   [2];
    logic [31:0] mul_src1   [2];
    logic [31:0] mul_src2   [2];
    logic [31:0] cell_res   [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_result [2];
    logic [31:0] cp0        [3];
    logic [31:0] cp1        [3];

    int checks = 0;
    int errors = 0;

    first_nios2_system_cpu_mul_seq #(.CELL_LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_src1(req_src1[0]), .req_src2(req_src2[0]),
        .mul_src1(mul_src1[0]), .mul_src2(mul_src2[0]), .mul_cell_result(cell_res[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0])
    );

    first_nios2_system_cpu_mul_seq #(.CELL_LATENCY(3)) u_lat3 (
        .clk(clk), .reset_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_src1(req_src1[1]), .req_src2(req_src2[1]),
        .mul_src1(mul_src1[1]), .mul_src2(mul_src2[1]), .mul_cell_result(cell_res[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiply cell models: low 32 bits of the product, registered.
    always @(posedge clk) begin
        cp0[0] <= mul_src1[0] * mul_src2[0];
        cp1[0] <= mul_src1[1] * mul_src2[1];
        cp1[1] <= cp1[0];
        cp1[2] <= cp1[1];
    end
    assign cell_res[0] = cp0[0];
    assign cell_res[1] = cp1[2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference: full 64-bit product of the extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        x = (op == 2'd2 || op == 2'd3) ? {{32{a[31]}}, a} : {32'h0, a};
        y = (op == 2'd3) ? {{32{b[31]}}, b} : {32'h0, b};
        p = x * y;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Operand pair expected at the cell input in a given cycle after accept.
    function automatic logic [63:0] exp_pair(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int c);
        if (op == 2'd0) return (c == 1) ? {a, b} : 64'h0;
        case (c)
            1: return {16'h0, a[15:0],  16'h0, b[15:0]};
            2: return {16'h0, a[31:16], 16'h0, b[15:0]};
            3: return {16'h0, a[15:0],  16'h0, b[31:16]};
            4: return {16'h0, a[31:16], 16'h0, b[31:16]};
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return $urandom_range(0, 65535);
            default: return $urandom;
        endcase
    endfunction

    // Run one operation from IDLE and check it. With hold > 0, rsp_ready
    // stays low for hold cycles, and a MUL 7x6 is then presented in the
    // same cycle that rsp_ready rises.
    task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int hold, input string tag);
        logic [31:0] s1 [0:40];
        logic [31:0] s2 [0:40];
        logic [63:0] ep;
        logic        ready_bad;
        int          lat, exp_lat, bad_ops, bad_c;
        exp_lat = ((op == 2'd0) ? 2 : 6) + lat_of(d);
        rsp_ready[d] = (hold == 0);
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: got %b want 1", tag, req_ready[d]);
        end
        req_valid[d] = 1'b1; req_op[d] = op; req_src1[d] = a; req_src2[d] = b;
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_op[d] = 2'($urandom); req_src1[d] = $urandom; req_src2[d] = $urandom;
        lat = 0; ready_bad = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            s1[cyc] = mul_src1[d]; s2[cyc] = mul_src2[d];
            if (req_ready[d] !== 1'b0) ready_bad = 1'b1;
            if (rsp_valid[d] === 1'b1) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d (0 = no response)", tag, lat, exp_lat);
        end
        if (lat == 0) return;
        checks++;
        if (rsp_result[d] !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h want %h", tag, rsp_result[d], exp_r);
        end
        bad_ops = 0; bad_c = 0;
        for (int c = 1; c <= lat; c++) begin
            ep = exp_pair(op, a, b, c);
            if ({s1[c], s2[c]} !== ep) begin
                if (bad_ops == 0) bad_c = c;
                bad_ops++;
            end
        end
        checks++;
        if (bad_ops != 0) begin
            errors++;
            ep = exp_pair(op, a, b, bad_c);
            $display("FAIL %s operands: cycle %0d got %h/%h want %h/%h", tag, bad_c,
                     s1[bad_c], s2[bad_c], ep[63:32], ep[31:0]);
        end
        checks++;
        if (ready_bad) begin
            errors++;
            $display("FAIL %s busy_ready: got 1 while busy want 0", tag);
        end
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[d] !== 1'b1 || rsp_result[d] !== exp_r || req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s stall: cycle %0d got valid=%b result=%h ready=%b want 1/%h/0",
                         tag, h, rsp_valid[d], rsp_result[d], req_ready[d], exp_r);
            end
        end
        if (hold > 0) begin
            rsp_ready[d] = 1'b1;
            req_valid[d] = 1'b1; req_op[d] = 2'd0; req_src1[d] = 32'd7; req_src2[d] = 32'd6;
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || rsp_result[d] !== exp_r) begin
            errors++;
            $display("FAIL %s handshake: got valid=%b ready=%b result=%h want 0/1/%h",
                     tag, rsp_valid[d], req_ready[d], rsp_result[d], exp_r);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_op[d] = 2'd0;
            req_src1[d] = 32'h0; req_src2[d] = 32'h0; rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_valid[d] !== 1'b0 || rsp_result[d] !== 32'h0 || mul_src1[d] !== 32'h0 ||
                mul_src2[d] !== 32'h0 || req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got v=%b r=%h s1=%h s2=%h rdy=%b want 0/0/0/0/0", d,
                         rsp_valid[d], rsp_result[d], mul_src1[d], mul_src2[d], req_ready[d]);
            end
            rst_n[d] = 1'b1;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release inst%0d: got req_ready=%b want 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_directed();
        for (int d = 0; d < 2; d++) begin
            run_op(d, 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0, "mul_basic");
            run_op(d, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulxuu_ones");
            run_op(d, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulxss_ones");
            run_op(d, 2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulxss_min");
            run_op(d, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulxsu_ones");
            run_op(d, 2'd2, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 0, "mulxsu_pos");
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 20; n++) begin
                op = 2'($urandom_range(0, 3));
                a = pick_operand();
                b = pick_operand();
                run_op(d, op, a, b, ref_mul(op, a, b), 0, "random");
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        for (int d = 0; d < 2; d++) begin
            a = $urandom; b = $urandom;
            run_op(d, 2'd3, a, b, ref_mul(2'd3, a, b), 5, "bp_hold");
            run_op(d, 2'd0, 32'd7, 32'd6, 32'h0000_002A, 0, "bp_next");
        end
    endtask

    task automatic test_reset_mid();
        logic quiet_bad;
        for (int d = 0; d < 2; d++) begin
            rsp_ready[d] = 1'b1;
            req_valid[d] = 1'b1; req_op[d] = 2'd1; req_src1[d] = $urandom; req_src2[d] = $urandom;
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n[d] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0 || rsp_result[d] !== 32'h0 ||
                mul_src1[d] !== 32'h0 || mul_src2[d] !== 32'h0) begin
                errors++;
                $display("FAIL midreset_state inst%0d: got v=%b rdy=%b r=%h s1=%h s2=%h want 0/0/0/0/0", d,
                         rsp_valid[d], req_ready[d], rsp_result[d], mul_src1[d], mul_src2[d]);
            end
            rst_n[d] = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL midreset_ready inst%0d: got %b want 1", d, req_ready[d]);
            end
            quiet_bad = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (rsp_valid[d] !== 1'b0 || mul_src1[d] !== 32'h0 || mul_src2[d] !== 32'h0) quiet_bad = 1'b1;
                @(posedge clk); #1;
            end
            checks++;
            if (quiet_bad) begin
                errors++;
                $display("FAIL midreset_quiet inst%0d: got activity after abort want none", d);
            end
            run_op(d, 2'd0, 32'd7, 32'd6, 32'h0000_002A, 0, "mul_after_reset");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
